// File: rtl/complex_pipeline_pkg.sv
// complex_pipeline_pkg
//   Shared definitions for the four-stage register/ALU/memory pipeline:
//   datapath widths and the ALU operation codes.
package complex_pipeline_pkg;

   localparam int DATA_W = 16;
   localparam int REG_W  = 4;
   localparam int ADDR_W = 8;
   localparam int NREGS  = 1 << REG_W;
   localparam int NMEM   = 1 << ADDR_W;

   // Codes 12..15 are unassigned and produce a zero result.
   typedef enum logic [3:0] {
      ADD  = 4'd0,
      SUB  = 4'd1,
      MUL  = 4'd2,
      SELA = 4'd3,
      SELB = 4'd4,
      AND  = 4'd5,
      OR   = 4'd6,
      XOR  = 4'd7,
      NEGA = 4'd8,
      NEGB = 4'd9,
      SRA  = 4'd10,
      SLA  = 4'd11
   } func_e;

endpackage

// File: rtl/complex_pipeline_alu.sv
// pipeline_alu
//   Purely combinational 16-bit ALU. All results wrap to DATA_W bits;
//   no carry or overflow is reported.
//   Ports:
//     a, b  : operands
//     func  : operation code (func_e encoding, 12..15 give 0)
//     z     : result
module pipeline_alu
   import complex_pipeline_pkg::*;
(
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic [3:0]        func,
   output logic [DATA_W-1:0] z
);

   always_comb begin
      z = '0;
      case (func)
         ADD:     z = a + b;
         SUB:     z = a - b;
         MUL:     z = a * b;            // low half of the product
         SELA:    z = a;
         SELB:    z = b;
         AND:     z = a & b;
         OR:      z = a | b;
         XOR:     z = a ^ b;
         NEGA:    z = -a;
         NEGB:    z = -b;
         SRA:     z = a >> 1;           // logical shift, zero fill
         SLA:     z = a << 1;
         default: z = '0;
      endcase
   end

endmodule

// File: rtl/complex_pipeline.sv
// complex_pipeline
//   Four-stage pipeline, one instruction per clock, no stalls:
//     S1  read operands (with write-through from S3), latch rd/func/addr
//     S2  ALU
//     S3  write register file, drive Zout
//     S4  write data memory with the S3 result
//   A read one instruction after its producer sees the old register value;
//   two or more instructions later it sees the new one.
//   Ports:
//     clk, rst_n     : clock, asynchronous active-low reset
//     rs1, rs2       : source register indices
//     rd             : destination register index
//     func           : ALU operation
//     addr           : data-memory write address
//     Zout           : registered result of the instruction in S3
module complex_pipeline
   import complex_pipeline_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic [REG_W-1:0]  rs1,
   input  logic [REG_W-1:0]  rs2,
   input  logic [REG_W-1:0]  rd,
   input  logic [3:0]        func,
   input  logic [ADDR_W-1:0] addr,
   output logic [DATA_W-1:0] Zout
);

   logic [DATA_W-1:0] regbank [NREGS];
   logic [DATA_W-1:0] membank [NMEM];

   // S1 registers
   logic [DATA_W-1:0] s1_a, s1_b;
   logic [REG_W-1:0]  s1_rd;
   logic [3:0]        s1_func;
   logic [ADDR_W-1:0] s1_addr;
   logic              s1_v;
   // S2 registers
   logic [DATA_W-1:0] s2_z;
   logic [REG_W-1:0]  s2_rd;
   logic [ADDR_W-1:0] s2_addr;
   logic              s2_v;
   // S3 registers (Zout is the S3 data register)
   logic [ADDR_W-1:0] s3_addr;
   logic              s3_v;

   logic [DATA_W-1:0] alu_z;
   logic [DATA_W-1:0] rd_a, rd_b;

   pipeline_alu u_alu (
      .a    (s1_a),
      .b    (s1_b),
      .func (s1_func),
      .z    (alu_z)
   );

   // Write-through: the S3 write lands on the same edge S1 samples, so S1
   // takes the value being written rather than the stale array entry.
   always_comb begin
      rd_a = regbank[rs1];
      rd_b = regbank[rs2];
      if (s2_v && (s2_rd == rs1)) rd_a = s2_z;
      if (s2_v && (s2_rd == rs2)) rd_b = s2_z;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // Zeroed operands make the flushed slots compute 0 whatever func is;
         // the valid bits keep them from writing anything.
         s1_a    <= '0;
         s1_b    <= '0;
         s1_rd   <= '0;
         s1_func <= '0;
         s1_addr <= '0;
         s1_v    <= 1'b0;
         s2_z    <= '0;
         s2_rd   <= '0;
         s2_addr <= '0;
         s2_v    <= 1'b0;
         s3_addr <= '0;
         s3_v    <= 1'b0;
         Zout    <= '0;
      end else begin
         s1_a    <= rd_a;
         s1_b    <= rd_b;
         s1_rd   <= rd;
         s1_func <= func;
         s1_addr <= addr;
         s1_v    <= 1'b1;
         s2_z    <= alu_z;
         s2_rd   <= s1_rd;
         s2_addr <= s1_addr;
         s2_v    <= s1_v;
         Zout    <= s2_z;
         s3_addr <= s2_addr;
         s3_v    <= s2_v;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREGS; i++) regbank[i] <= DATA_W'(i);
      end else if (s2_v) begin
         regbank[s2_rd] <= s2_z;
      end
   end

   // Data memory is not reset; only valid S4 slots write it.
   always_ff @(posedge clk) begin
      if (s3_v) membank[s3_addr] <= Zout;
   end

endmodule

// File: tb/tb_complex_pipeline.sv
module tb_complex_pipeline;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [3:0]  rs1 = '0, rs2 = '0, rd = '0, func = '0;
   logic [7:0]  addr = '0;
   logic [15:0] Zout;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   typedef struct {
      logic [15:0] z;
      logic [7:0]  a;
      logic [3:0]  d;
      int          due;
   } exp_t;

   exp_t zq[$];
   exp_t mq[$];

   // Reference register file: a write becomes visible to an instruction
   // issued two or more slots after its producer.
   logic [15:0] mreg [16];
   logic        w1v, w2v;
   logic [3:0]  w1rd, w2rd;
   logic [15:0] w1z, w2z;

   complex_pipeline dut (
      .clk   (clk),
      .rst_n (rst_n),
      .rs1   (rs1),
      .rs2   (rs2),
      .rd    (rd),
      .func  (func),
      .addr  (addr),
      .Zout  (Zout)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] model_alu(input logic [15:0] a, input logic [15:0] b,
                                             input logic [3:0] f);
      logic [31:0] p;
      p = a * b;
      case (f)
         4'd0:    return a + b;
         4'd1:    return a + (~b) + 16'd1;
         4'd2:    return p[15:0];
         4'd3:    return a;
         4'd4:    return b;
         4'd5:    return a & b;
         4'd6:    return a | b;
         4'd7:    return a ^ b;
         4'd8:    return (~a) + 16'd1;
         4'd9:    return (~b) + 16'd1;
         4'd10:   return {1'b0, a[15:1]};
         4'd11:   return {a[14:0], 1'b0};
         default: return 16'd0;
      endcase
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 16; i++) mreg[i] = 16'(i);
      w1v = 1'b0; w2v = 1'b0;
      w1rd = '0; w2rd = '0; w1z = '0; w2z = '0;
      zq.delete();
      mq.delete();
   endtask

   // Issue one instruction, advance one clock and score everything due.
   task automatic step(input logic [3:0] s1, input logic [3:0] s2, input logic [3:0] d,
                       input logic [3:0] f, input logic [7:0] a);
      logic [15:0] z;
      exp_t e;
      rs1 = s1; rs2 = s2; rd = d; func = f; addr = a;
      if (w2v) mreg[w2rd] = w2z;
      z = model_alu(mreg[s1], mreg[s2], f);
      w2v = w1v; w2rd = w1rd; w2z = w1z;
      w1v = 1'b1; w1rd = d; w1z = z;
      @(posedge clk);
      #1;
      cyc++;
      zq.push_back('{z: z, a: a, d: d, due: cyc + 2});
      while (zq.size() > 0 && zq[0].due == cyc) begin
         e = zq.pop_front();
         checks++;
         if (Zout !== e.z) begin
            errors++;
            $display("FAIL zout cyc=%0d got=%h exp=%h", cyc, Zout, e.z);
         end
         checks++;
         if (dut.regbank[e.d] !== e.z) begin
            errors++;
            $display("FAIL regwb r%0d cyc=%0d got=%h exp=%h", e.d, cyc, dut.regbank[e.d], e.z);
         end
         e.due = cyc + 1;
         mq.push_back(e);
      end
      while (mq.size() > 0 && mq[0].due == cyc) begin
         e = mq.pop_front();
         checks++;
         if (dut.membank[e.a] !== e.z) begin
            errors++;
            $display("FAIL memwr [%0d] cyc=%0d got=%h exp=%h", e.a, cyc, dut.membank[e.a], e.z);
         end
      end
   endtask

   task automatic nop();
      step(4'd11, 4'd0, 4'd11, 4'd3, 8'd255);
   endtask

   task automatic check_regs_reset(input string tag);
      for (int i = 0; i < 16; i++) begin
         checks++;
         if (dut.regbank[i] !== 16'(i)) begin
            errors++;
            $display("FAIL %s regbank[%0d] got=%h exp=%h", tag, i, dut.regbank[i], 16'(i));
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (Zout !== 16'h0000) begin
         errors++;
         $display("FAIL reset_zout got=%h exp=0000", Zout);
      end
      check_regs_reset("reset");
      rst_n = 1'b1;
      model_reset();
   endtask

   task automatic test_basic();
      step(4'd3, 4'd5, 4'd10, 4'd0, 8'd125);   // ADD r3,r5 -> r10
      step(4'd3, 4'd8, 4'd12, 4'd2, 8'd126);   // MUL r3,r8 -> r12
      step(4'd10, 4'd5, 4'd14, 4'd1, 8'd128);  // SUB r10,r5 -> r14 (distance 2)
      checks++;
      if (Zout !== 16'd8) begin
         errors++;
         $display("FAIL add_zout_n2 got=%0d exp=8", Zout);
      end
      step(4'd7, 4'd0, 4'd13, 4'd11, 8'd127);  // SLA r7 -> r13
      checks++;
      if (dut.membank[125] !== 16'd8) begin
         errors++;
         $display("FAIL add_mem_n3 got=%0d exp=8", dut.membank[125]);
      end
      step(4'd10, 4'd5, 4'd15, 4'd1, 8'd129);  // SUB r10,r5 -> r15
      step(4'd12, 4'd13, 4'd0, 4'd0, 8'd130);  // ADD r12,r13 -> r0
      repeat (4) nop();
      checks++;
      if (dut.membank[126] !== 16'd24) begin errors++; $display("FAIL mul_mem got=%0d exp=24", dut.membank[126]); end
      checks++;
      if (dut.membank[128] !== 16'd3) begin errors++; $display("FAIL bypass_mem got=%0d exp=3", dut.membank[128]); end
      checks++;
      if (dut.membank[127] !== 16'd14) begin errors++; $display("FAIL sla_mem got=%0d exp=14", dut.membank[127]); end
      checks++;
      if (dut.membank[129] !== 16'd3) begin errors++; $display("FAIL sub_mem got=%0d exp=3", dut.membank[129]); end
      checks++;
      if (dut.membank[130] !== 16'd38) begin errors++; $display("FAIL add_mem got=%0d exp=38", dut.membank[130]); end
      checks++;
      if (dut.regbank[0] !== 16'd38) begin errors++; $display("FAIL r0_wb got=%0d exp=38", dut.regbank[0]); end
   endtask

   task automatic test_back_to_back();
      step(4'd1, 4'd2, 4'd4, 4'd0, 8'd138);    // ADD r1,r2 -> r4
      step(4'd4, 4'd1, 4'd5, 4'd1, 8'd139);    // SUB r4,r1 -> r5, stale r4
      repeat (3) nop();
      checks++;
      if (dut.regbank[5] !== 16'd3) begin
         errors++;
         $display("FAIL stale_operand got=%0d exp=3", dut.regbank[5]);
      end
   endtask

   task automatic test_neg_mul();
      step(4'd1, 4'd0, 4'd6, 4'd8, 8'd131);    // NEGA r1
      nop();
      nop();
      checks++;
      if (Zout !== 16'hFFFF) begin
         errors++;
         $display("FAIL nega got=%h exp=ffff", Zout);
      end
      step(4'd8, 4'd0, 4'd14, 4'd11, 8'd133);
      step(4'd8, 4'd0, 4'd15, 4'd11, 8'd134);
      for (int k = 0; k < 4; k++) begin
         step(4'd14, 4'd0, 4'd14, 4'd11, 8'd135);
         step(4'd15, 4'd0, 4'd15, 4'd11, 8'd136);
      end
      nop();
      step(4'd15, 4'd14, 4'd7, 4'd2, 8'd137);  // MUL 0x100 * 0x100
      nop();
      nop();
      checks++;
      if (Zout !== 16'h0000) begin
         errors++;
         $display("FAIL mul_trunc got=%h exp=0000", Zout);
      end
      checks++;
      if (dut.regbank[15] !== 16'h0100) begin
         errors++;
         $display("FAIL r15_shift got=%h exp=0100", dut.regbank[15]);
      end
   endtask

   task automatic test_alu_all();
      for (int f = 0; f < 16; f++) step(4'd5, 4'd3, 4'd12, 4'(f), 8'(200 + f));
      repeat (3) nop();
   endtask

   task automatic test_random();
      logic [3:0] d;
      for (int k = 0; k < 60; k++) begin
         d = 4'($urandom_range(0, 15));
         if (d == 4'd11) d = 4'd12;
         step(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), d,
              4'($urandom_range(0, 15)), 8'($urandom_range(140, 250)));
      end
      repeat (4) nop();
   endtask

   task automatic test_midstream_reset();
      step(4'd11, 4'd0, 4'd1, 4'd3, 8'd0);     // mem[0] = 11
      repeat (3) nop();
      step(4'd11, 4'd0, 4'd1, 4'd3, 8'd125);
      step(4'd11, 4'd0, 4'd2, 4'd3, 8'd126);
      step(4'd11, 4'd0, 4'd3, 4'd3, 8'd127);
      rst_n = 1'b0;
      #1;
      checks++;
      if (Zout !== 16'h0000) begin
         errors++;
         $display("FAIL async_zout got=%h exp=0000", Zout);
      end
      check_regs_reset("midreset");
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_reset();
      repeat (5) nop();
      checks++;
      if (dut.membank[125] !== 16'd8) begin errors++; $display("FAIL flush_mem125 got=%0d exp=8", dut.membank[125]); end
      checks++;
      if (dut.membank[126] !== 16'd24) begin errors++; $display("FAIL flush_mem126 got=%0d exp=24", dut.membank[126]); end
      checks++;
      if (dut.membank[127] !== 16'd14) begin errors++; $display("FAIL flush_mem127 got=%0d exp=14", dut.membank[127]); end
      checks++;
      if (dut.membank[0] !== 16'd11) begin errors++; $display("FAIL flush_mem0 got=%0d exp=11", dut.membank[0]); end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_basic();
      test_back_to_back();
      test_neg_mul();
      test_alu_all();
      test_random();
      test_midstream_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/complex_pipeline.md
COMPLEX_PIPELINE -- requirements
Module: complex_pipeline

Interface
REQ-001 SHALL have ports: clk  input  1  sole clock, all state updates on rising edge.
REQ-002 SHALL have ports: rst_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL have ports: rs1  input  4  source register A index.
REQ-004 SHALL have ports: rs2  input  4  source register B index.
REQ-005 SHALL have ports: rd  input  4  destination register index.
REQ-006 SHALL have ports: func  input  4  ALU operation code.
REQ-007 SHALL have ports: addr  input  8  data-memory write address.
REQ-008 SHALL have ports: Zout  output  16  registered ALU result of the instruction in stage 3.
REQ-009 SHALL have internal arrays regbank (16 x 16 bit) and membank (256 x 16 bit), reachable by hierarchical name for bench preload and inspection.

Function
REQ-010 SHALL accept one instruction (rs1, rs2, rd, func, addr) per clock, with no stall and no valid qualifier.
REQ-011 SHALL implement 4 stages: S1 at issue edge N latches A=regbank[rs1], B=regbank[rs2], rd, func, addr; S2 at N+1 latches Z=ALU(A,B,func), rd, addr; S3 at N+2 writes regbank[rd]=Z and latches Zout=Z and addr; S4 at N+3 writes membank[addr]=Zout.
REQ-012 SHALL have latencies: register writeback 2 cycles after issue, Zout 2 cycles, memory write 3 cycles.
REQ-013 SHALL decode func (all 16-bit, results truncated to 16 bits): 0 A+B; 1 A-B; 2 A*B (low 16); 3 A; 4 B; 5 A&B; 6 A|B; 7 A^B; 8 -A; 9 -B; 10 A>>1 (logical); 11 A<<1; 12-15 result 0.
REQ-014 SHALL bypass the register file on S1 reads: if S3 writes the register S1 reads on the same edge, S1 SHALL latch the new value (write-through), so dependence distance 2 is hazard-free.
REQ-015 SHALL NOT forward at dependence distance 1; such a read SHALL return the pre-write register value (software separates dependents by ≥1 independent instruction).
REQ-016 SHALL wrap on overflow and carry and SHALL NOT flag it; an rd or addr value that does not fit the port width is truncated to the port width by the bench/driver.
REQ-017 SHALL give S3 and S4 write-after-write to the same location the program-order result (later instruction wins).

Reset
REQ-018 SHALL on rst_n low immediately clear all pipeline registers to 0 (func treated as 12 -> result 0) and Zout to 0.
REQ-019 SHALL during reset load regbank[i]=i for i=0..15; membank SHALL NOT be reset.
REQ-020 SHALL, when reset is released mid-stream, not write the flushed (zeroed) slots into membank or regbank; writes resume only for instructions issued after release.

Structure
REQ-021 SHALL place in package complex_pipeline_pkg: the func opcode enum (ADD, SUB, MUL, SELA, SELB, AND, OR, XOR, NEGA, NEGB, SRA, SLA), data width 16, register index width 4, address width 8.
REQ-022 SHALL implement the combinational ALU as the single sub-module pipeline_alu (A, B, func -> Z).
REQ-023 SHALL carry a per-stage valid bit, cleared by reset and set on issue, that gates S3/S4 writes (implements REQ-020).

Verification
REQ-024 SHALL pass: after reset, issue ADD r3,r5->r10 addr125 -> Zout=8 at N+2; mem[125]=8 at N+3.
REQ-025 SHALL pass: MUL r3,r8->r12 addr126; SUB r10,r5->r14 addr128 at distance 2 from the ADD -> mem[126]=24, mem[128]=3 (bypass).
REQ-026 SHALL pass: SLA r7->r13 addr127; SUB r10,r5->r15 addr129; ADD r12,r13->rd 0 addr130 -> mem[127]=14, mem[129]=3, mem[130]=38, regbank[0]=38.
REQ-027 SHALL pass: back-to-back ADD r1,r2->r4 then SUB r4,r1->r5 (distance 1) -> r5 = 4-1 = 3 (stale operand), not 2.
REQ-028 SHALL pass: func 8 on r1 -> 0xFFFF; func 2 with r15=0x0100 written, r14=0x0100 -> 0x0000 (low 16 bits).
REQ-029 SHALL pass: assert rst_n mid-stream -> Zout=0 immediately, regbank[i]=i, no membank write for in-flight instructions.
